// File: rtl/mem_wb_forward.sv
// MEM/WB pipeline registers with EX-stage operand forwarding, load-use
// detection and a retired-instruction counter.
module mem_wb_forward #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_regWrite,
  input  logic              ex_memToReg,
  input  logic [DATA_W-1:0] ex_aluResult,
  input  logic [4:0]        ex_writeReg,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [4:0]        ex_rs,
  input  logic [4:0]        ex_rt,
  input  logic [DATA_W-1:0] readRs,
  input  logic [DATA_W-1:0] readRt,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              load_use_stall,
  output logic              wb_regWrite,
  output logic [4:0]        wb_writeReg,
  output logic [DATA_W-1:0] wb_writeData,
  output logic [31:0]       retired
);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  logic              vld_p1, regwrite_p1, memtoreg_p1;
  logic [DATA_W-1:0] aluresult_p1;
  logic [4:0]        writereg_p1;

  logic              vld_p2, regwrite_p2, memtoreg_p2;
  logic [DATA_W-1:0] aluresult_p2, memdata_p2;
  logic [4:0]        writereg_p2;

  logic [31:0]       retired_q;

  logic m_fwd_rs, m_fwd_rt, w_fwd_rs, w_fwd_rt, m_alu_wr, m_load_wr;

  // EX -> M boundary; a held or squashed EX slot becomes a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      regwrite_p1  <= 1'b0;
      memtoreg_p1  <= 1'b0;
      aluresult_p1 <= '0;
      writereg_p1  <= '0;
    end else if (stall || flush) begin
      vld_p1       <= 1'b0;
      regwrite_p1  <= 1'b0;
      memtoreg_p1  <= 1'b0;
      aluresult_p1 <= '0;
      writereg_p1  <= '0;
    end else begin
      vld_p1       <= ex_valid;
      regwrite_p1  <= ex_regWrite;
      memtoreg_p1  <= ex_memToReg;
      aluresult_p1 <= ex_aluResult;
      writereg_p1  <= ex_writeReg;
    end
  end

  // M -> W boundary plus retirement count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2       <= 1'b0;
      regwrite_p2  <= 1'b0;
      memtoreg_p2  <= 1'b0;
      aluresult_p2 <= '0;
      memdata_p2   <= '0;
      writereg_p2  <= '0;
      retired_q    <= '0;
    end else begin
      vld_p2       <= vld_p1;
      regwrite_p2  <= regwrite_p1;
      memtoreg_p2  <= memtoreg_p1;
      aluresult_p2 <= aluresult_p1;
      memdata_p2   <= memtoreg_p1 ? mem_rdata : '0;
      writereg_p2  <= writereg_p1;
      if (vld_p2)
        retired_q <= retired_q + 32'd1;
    end
  end

  assign retired      = retired_q;
  assign wb_writeReg  = writereg_p2;
  assign wb_writeData = memtoreg_p2 ? memdata_p2 : aluresult_p2;
  assign wb_regWrite  = vld_p2 & regwrite_p2 & (writereg_p2 != 5'd0);

  // A load's data is not available in M, so only ALU results forward from there
  assign m_alu_wr  = vld_p1 & regwrite_p1 & ~memtoreg_p1 & (writereg_p1 != 5'd0);
  assign m_load_wr = vld_p1 & regwrite_p1 &  memtoreg_p1 & (writereg_p1 != 5'd0);

  assign m_fwd_rs = m_alu_wr & (writereg_p1 == ex_rs);
  assign m_fwd_rt = m_alu_wr & (writereg_p1 == ex_rt);
  assign w_fwd_rs = wb_regWrite & (writereg_p2 == ex_rs);
  assign w_fwd_rt = wb_regWrite & (writereg_p2 == ex_rt);

  assign load_use_stall = m_load_wr & ((writereg_p1 == ex_rs) | (writereg_p1 == ex_rt));

  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    opA  = readRs;
    opB  = readRt;
    if (m_fwd_rs) begin
      fwdA = FWD_M;
      opA  = aluresult_p1;
    end else if (w_fwd_rs) begin
      fwdA = FWD_W;
      opA  = wb_writeData;
    end
    if (m_fwd_rt) begin
      fwdB = FWD_M;
      opB  = aluresult_p1;
    end else if (w_fwd_rt) begin
      fwdB = FWD_W;
      opB  = wb_writeData;
    end
  end

endmodule

// File: tb/tb_mem_wb_forward.sv
// Directed bench for mem_wb_forward: forwarding paths, load-use, bubbles,
// counter wrap and asynchronous reset.
module tb_mem_wb_forward;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        ex_valid, ex_regWrite, ex_memToReg;
  logic [31:0] ex_aluResult, mem_rdata, readRs, readRt;
  logic [4:0]  ex_writeReg, ex_rs, ex_rt;
  logic [31:0] opA, opB, wb_writeData, retired;
  logic [1:0]  fwdA, fwdB;
  logic        load_use_stall, wb_regWrite;
  logic [4:0]  wb_writeReg;

  int errors = 0;
  int checks = 0;

  mem_wb_forward dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memToReg(ex_memToReg),
    .ex_aluResult(ex_aluResult), .ex_writeReg(ex_writeReg), .mem_rdata(mem_rdata),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .readRs(readRs), .readRt(readRt),
    .opA(opA), .opB(opB), .fwdA(fwdA), .fwdB(fwdB),
    .load_use_stall(load_use_stall), .wb_regWrite(wb_regWrite),
    .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic mtr,
                        input logic [31:0] alu, input logic [4:0] wr,
                        input logic [4:0] rs, input logic [4:0] rt);
    ex_valid = v; ex_regWrite = rw; ex_memToReg = mtr;
    ex_aluResult = alu; ex_writeReg = wr; ex_rs = rs; ex_rt = rt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_rdata = 32'h0; readRs = 32'h0; readRt = 32'h0;
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_rdata = 32'h5555;
    readRs = 32'h1111_1111; readRt = 32'h2222_2222;
    set_ex(1'b1, 1'b1, 1'b0, 32'h42, 5'd3, 5'd3, 5'd3);
    #1;
    tick();
    tick();
    checks++; if (wb_regWrite !== 1'b0) begin errors++; $display("FAIL rst_wb_regWrite got=%b exp=0", wb_regWrite); end
    checks++; if (fwdA !== 2'b00 || fwdB !== 2'b00) begin errors++; $display("FAIL rst_fwd got=%b/%b exp=00/00", fwdA, fwdB); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_lus got=%b exp=0", load_use_stall); end
    checks++; if (retired !== 32'h0) begin errors++; $display("FAIL rst_retired got=%h exp=0", retired); end
    checks++; if (wb_writeReg !== 5'd0 || wb_writeData !== 32'h0) begin errors++; $display("FAIL rst_wb got=%h/%h exp=0/0", wb_writeReg, wb_writeData); end
    checks++; if (opA !== 32'h1111_1111 || opB !== 32'h2222_2222) begin errors++; $display("FAIL rst_ops got=%h/%h exp=11111111/22222222", opA, opB); end
    rst_n = 1'b1;
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    readRs = 32'hDEAD_0001; readRt = 32'hBEEF_0003;
    set_ex(1'b1, 1'b1, 1'b0, 32'h12, 5'd5, 5'd0, 5'd0);   // I1: r5 = 0x12
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 32'h34, 5'd6, 5'd5, 5'd3);   // I2: r6 = 0x34, reads r5,r3
    #1;
    checks++; if (fwdA !== 2'b10 || opA !== 32'h12) begin errors++; $display("FAIL b2b_m_fwdA got=%b/%h exp=10/12", fwdA, opA); end
    checks++; if (fwdB !== 2'b00 || opB !== 32'hBEEF_0003) begin errors++; $display("FAIL b2b_rf_fwdB got=%b/%h exp=00/beef0003", fwdB, opB); end
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 32'h56, 5'd6, 5'd5, 5'd6);   // I3: r6 = 0x56, reads r5,r6
    #1;
    checks++; if (fwdA !== 2'b01 || opA !== 32'h12) begin errors++; $display("FAIL b2b_w_fwdA got=%b/%h exp=01/12", fwdA, opA); end
    checks++; if (fwdB !== 2'b10 || opB !== 32'h34) begin errors++; $display("FAIL b2b_m_fwdB got=%b/%h exp=10/34", fwdB, opB); end
    checks++; if (wb_regWrite !== 1'b1 || wb_writeReg !== 5'd5 || wb_writeData !== 32'h12) begin errors++; $display("FAIL b2b_wb got=%b/%0d/%h exp=1/5/12", wb_regWrite, wb_writeReg, wb_writeData); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL b2b_retired0 got=%0d exp=0", retired); end
    tick();
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 5'd6, 5'd6);    // I4: reads r6 twice
    #1;
    checks++; if (fwdA !== 2'b10 || opA !== 32'h56 || fwdB !== 2'b10) begin errors++; $display("FAIL b2b_priority got=%b/%h/%b exp=10/56/10", fwdA, opA, fwdB); end
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL b2b_retired1 got=%0d exp=1", retired); end
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_load_use();
    do_reset();
    readRs = 32'h2222; readRt = 32'h7777;
    set_ex(1'b1, 1'b1, 1'b1, 32'h100, 5'd7, 5'd0, 5'd0); // load r7
    tick();
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 5'd2, 5'd7);
    mem_rdata = 32'hABCD;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_detect got=%b exp=1", load_use_stall); end
    checks++; if (fwdB !== 2'b00 || opB !== 32'h7777) begin errors++; $display("FAIL lu_no_m_fwd got=%b/%h exp=00/7777", fwdB, opB); end
    stall = 1'b1;
    tick();
    stall = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if (fwdB !== 2'b01 || opB !== 32'hABCD) begin errors++; $display("FAIL lu_w_fwdB got=%b/%h exp=01/abcd", fwdB, opB); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_clear got=%b exp=0", load_use_stall); end
    checks++; if (wb_regWrite !== 1'b1 || wb_writeReg !== 5'd7 || wb_writeData !== 32'hABCD) begin errors++; $display("FAIL lu_wb got=%b/%0d/%h exp=1/7/abcd", wb_regWrite, wb_writeReg, wb_writeData); end
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reg0();
    do_reset();
    readRs = 32'hA0A0; readRt = 32'hB0B0;
    set_ex(1'b1, 1'b1, 1'b0, 32'h99, 5'd0, 5'd0, 5'd0);
    tick();
    set_ex(1'b1, 1'b1, 1'b1, 32'h0, 5'd0, 5'd0, 5'd0);    // a load to r0 next
    #1;
    checks++; if (fwdA !== 2'b00 || opA !== 32'hA0A0) begin errors++; $display("FAIL r0_m_fwdA got=%b/%h exp=00/a0a0", fwdA, opA); end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    checks++; if (wb_regWrite !== 1'b0 || fwdA !== 2'b00) begin errors++; $display("FAIL r0_wb got=%b/%b exp=0/00", wb_regWrite, fwdA); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL r0_lus got=%b exp=0", load_use_stall); end
  endtask

  task automatic test_flush_stall();
    for (int mode = 0; mode < 3; mode++) begin
      do_reset();
      set_ex(1'b1, 1'b1, 1'b0, 32'hAA, 5'd9, 5'd0, 5'd0);
      flush = (mode != 1);
      stall = (mode != 0);
      tick();
      flush = 1'b0; stall = 1'b0;
      set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd9, 5'd9);
      #1;
      checks++; if (fwdA !== 2'b00) begin errors++; $display("FAIL squash_m_fwd mode=%0d got=%b exp=00", mode, fwdA); end
      tick();
      checks++; if (wb_regWrite !== 1'b0) begin errors++; $display("FAIL squash_wb mode=%0d got=%b exp=0", mode, wb_regWrite); end
      tick();
      tick();
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL squash_retired mode=%0d got=%0d exp=0", mode, retired); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ex(1'b1, 1'b1, 1'b0, 32'h4, 5'd4, 5'd0, 5'd0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    checks++; if (retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffffffff", retired); end
    tick();
    checks++; if (retired !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", retired); end
  endtask

  task automatic test_async_reset();
    do_reset();
    readRs = 32'h9090; readRt = 32'h8080;
    set_ex(1'b1, 1'b1, 1'b0, 32'h1, 5'd8, 5'd0, 5'd0);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 32'h2, 5'd9, 5'd0, 5'd0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd9, 5'd8);
    #1;
    checks++; if (fwdA !== 2'b10 || fwdB !== 2'b01 || wb_regWrite !== 1'b1) begin errors++; $display("FAIL ar_pre got=%b/%b/%b exp=10/01/1", fwdA, fwdB, wb_regWrite); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wb_regWrite !== 1'b0 || wb_writeReg !== 5'd0 || wb_writeData !== 32'h0) begin errors++; $display("FAIL ar_wb got=%b/%0d/%h exp=0/0/0", wb_regWrite, wb_writeReg, wb_writeData); end
    checks++; if (fwdA !== 2'b00 || fwdB !== 2'b00 || opA !== 32'h9090 || opB !== 32'h8080) begin errors++; $display("FAIL ar_fwd got=%b/%b/%h/%h exp=00/00/9090/8080", fwdA, fwdB, opA, opB); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (retired !== 32'd0 || wb_regWrite !== 1'b0) begin errors++; $display("FAIL ar_no_retire got=%0d/%b exp=0/0", retired, wb_regWrite); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_reg0();
    test_flush_stall();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
